// File: rtl/fifo_128to16_pkg.sv
// ---------------------------------------------------------------------------
// fifo_128to16_pkg
// Shared constants for the 128-bit-in / 16-bit-out single-clock FIFO:
// depth and width defaults, flag thresholds, and the derived pointer and
// level widths used by the interface, the top level and the RAM.
// ---------------------------------------------------------------------------
package fifo_128to16_pkg;

  // Default geometry: 2048 x 128-bit write view, 16384 x 16-bit read view.
  localparam int unsigned DEF_WR_DEPTH_WIDTH   = 11;
  localparam int unsigned DEF_WR_DATA_WIDTH    = 128;
  localparam int unsigned DEF_RD_DEPTH_WIDTH   = 14;
  localparam int unsigned DEF_RD_DATA_WIDTH    = 16;

  // Default flag thresholds (write level for almost_full, read level for
  // almost_empty).
  localparam int unsigned DEF_ALMOST_FULL_NUM  = 508;
  localparam int unsigned DEF_ALMOST_EMPTY_NUM = 4;

  // Derived widths: each pointer carries one extra wrap bit, so levels span
  // 0..depth inclusive. The lane field selects a 16-bit slice of a word.
  localparam int unsigned DEF_LANE_WIDTH   = DEF_RD_DEPTH_WIDTH - DEF_WR_DEPTH_WIDTH;
  localparam int unsigned DEF_WR_PTR_WIDTH = DEF_WR_DEPTH_WIDTH + 1;
  localparam int unsigned DEF_RD_PTR_WIDTH = DEF_RD_DEPTH_WIDTH + 1;

endpackage : fifo_128to16_pkg

// File: rtl/fifo_128to16_sync_if.sv
// ---------------------------------------------------------------------------
// fifo_128to16_sync_if
// Bundles the write and read handshakes, flags and levels of the FIFO.
//   slave  : the FIFO side (takes wr_data/wr_en/rd_en, drives the rest)
//   master : the producer/consumer side (the mirror image)
// Signals:
//   wr_data, wr_en                     write word and request
//   wr_full, wr_water_level, almost_full   write-side status
//   rd_en                              read request
//   rd_data                            16-bit read word, one cycle after rd_en
//   rd_empty, rd_water_level, almost_empty read-side status
// ---------------------------------------------------------------------------
interface fifo_128to16_sync_if
  import fifo_128to16_pkg::*;
#(
  parameter int unsigned WR_DEPTH_WIDTH = DEF_WR_DEPTH_WIDTH,
  parameter int unsigned WR_DATA_WIDTH  = DEF_WR_DATA_WIDTH,
  parameter int unsigned RD_DEPTH_WIDTH = DEF_RD_DEPTH_WIDTH,
  parameter int unsigned RD_DATA_WIDTH  = DEF_RD_DATA_WIDTH
) ();

  logic [WR_DATA_WIDTH-1:0]  wr_data;
  logic                      wr_en;
  logic                      wr_full;
  logic [WR_DEPTH_WIDTH:0]   wr_water_level;
  logic                      almost_full;
  logic                      rd_en;
  logic [RD_DATA_WIDTH-1:0]  rd_data;
  logic                      rd_empty;
  logic [RD_DEPTH_WIDTH:0]   rd_water_level;
  logic                      almost_empty;

  modport slave (
    input  wr_data, wr_en, rd_en,
    output wr_full, wr_water_level, almost_full,
    output rd_data, rd_empty, rd_water_level, almost_empty
  );

  modport master (
    output wr_data, wr_en, rd_en,
    input  wr_full, wr_water_level, almost_full,
    input  rd_data, rd_empty, rd_water_level, almost_empty
  );

endinterface : fifo_128to16_sync_if

// File: rtl/fifo_sdp_ram.sv
// ---------------------------------------------------------------------------
// fifo_sdp_ram
// Simple dual-port RAM, one clock: synchronous write port and a registered
// read port. Written to map onto block RAM: no reset on the array or on the
// output register, and the read register only loads when re_i is high so
// the last read word is held.
// Ports:
//   clk_i              clock
//   we_i, waddr_i, wdata_i   write enable, address, data
//   re_i, raddr_i      read enable and address
//   rdata_o            registered read data (valid the cycle after re_i)
// ---------------------------------------------------------------------------
module fifo_sdp_ram #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:(1 << ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write port: store the incoming word at the write address.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: register the addressed word; hold it when not reading.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : fifo_sdp_ram

// File: rtl/fifo_128to16_sync.sv
// ---------------------------------------------------------------------------
// fifo_128to16_sync
// Single-clock width-converting FIFO: 128-bit words in, 16-bit lanes out,
// little-endian lane order (bits [15:0] of each word come out first).
// Ports:
//   clk   single clock for both sides
//   rst   synchronous active-high reset; zeroes pointers and rd_data,
//         leaves RAM contents alone (they are unreachable afterwards)
//   bus   fifo_128to16_sync_if.slave: write/read handshakes, flags, levels
// Flags and levels are combinational from the registered pointers, so a
// write accepted at one edge makes data readable at the very next edge.
// ---------------------------------------------------------------------------
module fifo_128to16_sync
  import fifo_128to16_pkg::*;
#(
  parameter int unsigned WR_DEPTH_WIDTH   = DEF_WR_DEPTH_WIDTH,
  parameter int unsigned WR_DATA_WIDTH    = DEF_WR_DATA_WIDTH,
  parameter int unsigned RD_DEPTH_WIDTH   = DEF_RD_DEPTH_WIDTH,
  parameter int unsigned RD_DATA_WIDTH    = DEF_RD_DATA_WIDTH,
  parameter int unsigned ALMOST_FULL_NUM  = DEF_ALMOST_FULL_NUM,
  parameter int unsigned ALMOST_EMPTY_NUM = DEF_ALMOST_EMPTY_NUM
) (
  input  logic                clk,
  input  logic                rst,
  fifo_128to16_sync_if.slave  bus
);

  localparam int unsigned LANE_W   = RD_DEPTH_WIDTH - WR_DEPTH_WIDTH;
  localparam int unsigned WR_PTR_W = WR_DEPTH_WIDTH + 1;
  localparam int unsigned RD_PTR_W = RD_DEPTH_WIDTH + 1;

  logic [WR_PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [RD_PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LANE_W-1:0]        rd_lane_q, rd_lane_d;
  logic                     rd_valid_q, rd_valid_d;

  logic [WR_PTR_W-1:0]      wr_level_s;
  logic [RD_PTR_W-1:0]      rd_level_s;
  logic                     wr_full_s;
  logic                     rd_empty_s;
  logic                     wr_accept_s;
  logic                     rd_accept_s;
  logic [WR_DATA_WIDTH-1:0] rd_word_s;
  logic [RD_DATA_WIDTH-1:0] rd_data_s;

  // Levels and flags from the current pointers. The write level uses the
  // read word pointer, so a partly read word still counts as occupied.
  always_comb begin
    wr_level_s  = wr_ptr_q - rd_ptr_q[RD_PTR_W-1:LANE_W];
    rd_level_s  = {wr_ptr_q, {LANE_W{1'b0}}} - rd_ptr_q;
    wr_full_s   = (wr_level_s == {1'b1, {WR_DEPTH_WIDTH{1'b0}}});
    rd_empty_s  = (rd_level_s == {RD_PTR_W{1'b0}});
    wr_accept_s = bus.wr_en & ~wr_full_s;
    rd_accept_s = bus.rd_en & ~rd_empty_s;
  end

  // Next-state pointers plus the lane to select on the RAM output next cycle.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_lane_d  = rd_lane_q;
    rd_valid_d = rd_valid_q;
    if (wr_accept_s) begin
      wr_ptr_d = wr_ptr_q + WR_PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_accept_s) begin
      rd_ptr_d   = rd_ptr_q + RD_PTR_W'(1);
      rd_lane_d  = rd_ptr_q[LANE_W-1:0];
      rd_valid_d = 1'b1;
    end else begin
      rd_ptr_d   = rd_ptr_q;
      rd_lane_d  = rd_lane_q;
      rd_valid_d = rd_valid_q;
    end
  end

  // Pointer and read-lane state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= {WR_PTR_W{1'b0}};
      rd_ptr_q   <= {RD_PTR_W{1'b0}};
      rd_lane_q  <= {LANE_W{1'b0}};
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_lane_q  <= rd_lane_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  fifo_sdp_ram #(
    .ADDR_WIDTH (WR_DEPTH_WIDTH),
    .DATA_WIDTH (WR_DATA_WIDTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_accept_s),
    .waddr_i (wr_ptr_q[WR_DEPTH_WIDTH-1:0]),
    .wdata_i (bus.wr_data),
    .re_i    (rd_accept_s),
    .raddr_i (rd_ptr_q[RD_DEPTH_WIDTH-1:LANE_W]),
    .rdata_o (rd_word_s)
  );

  // Lane mux on the registered RAM word. The RAM output register has no
  // reset, so rd_valid_q forces zero until the first read after reset.
  always_comb begin
    rd_data_s = {RD_DATA_WIDTH{1'b0}};
    if (rd_valid_q) begin
      rd_data_s = rd_word_s[rd_lane_q*RD_DATA_WIDTH +: RD_DATA_WIDTH];
    end else begin
      rd_data_s = {RD_DATA_WIDTH{1'b0}};
    end
  end

  assign bus.rd_data        = rd_data_s;
  assign bus.wr_full        = wr_full_s;
  assign bus.rd_empty       = rd_empty_s;
  assign bus.wr_water_level = wr_level_s;
  assign bus.rd_water_level = rd_level_s;
  assign bus.almost_full    = (wr_level_s >= WR_PTR_W'(ALMOST_FULL_NUM));
  assign bus.almost_empty   = (rd_level_s <= RD_PTR_W'(ALMOST_EMPTY_NUM));

endmodule : fifo_128to16_sync

// File: tb/tb_fifo_128to16_sync.sv
// ---------------------------------------------------------------------------
// tb_fifo_128to16_sync
// Self-checking bench: a short table of hand-computed vectors for the
// single-word path, then directed fill/drain/concurrent/reset sequences
// checked every cycle against a lane-queue reference model.
// ---------------------------------------------------------------------------
module tb_fifo_128to16_sync;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fifo_128to16_sync_if u_if ();

  fifo_128to16_sync u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of 16-bit lanes still to be read, plus the
  // expected rd_data register.
  logic [15:0] mq [$];
  logic [15:0] m_rd_data;

  typedef struct {
    logic         we;
    logic [127:0] wd;
    logic         re;
    logic [15:0]  rd;
    logic         emp;
    logic [11:0]  wl;
    logic [14:0]  rl;
    logic         ae;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_edge(input logic we, input logic [127:0] d, input logic re);
    u_if.wr_en   = we;
    u_if.wr_data = d;
    u_if.rd_en   = re;
    @(posedge clk);
    #1;
    u_if.wr_en = 1'b0;
    u_if.rd_en = 1'b0;
  endtask

  function automatic int m_words();
    return (mq.size() + 7) / 8;
  endfunction

  task automatic m_check();
    chk("rd_data",      32'(u_if.rd_data),        32'(m_rd_data));
    chk("rd_empty",     32'(u_if.rd_empty),       32'(mq.size() == 0));
    chk("wr_full",      32'(u_if.wr_full),        32'(m_words() == 2048));
    chk("wr_level",     32'(u_if.wr_water_level), 32'(m_words()));
    chk("rd_level",     32'(u_if.rd_water_level), 32'(mq.size()));
    chk("almost_full",  32'(u_if.almost_full),    32'(m_words() >= 508));
    chk("almost_empty", 32'(u_if.almost_empty),   32'(mq.size() <= 4));
  endtask

  task automatic m_cycle(input logic we, input logic [127:0] d, input logic re);
    bit wa;
    bit ra;
    wa = we && (m_words() != 2048);
    ra = re && (mq.size() != 0);
    drive_edge(we, d, re);
    if (ra) m_rd_data = mq.pop_front();
    if (wa) for (int k = 0; k < 8; k++) mq.push_back(d[16*k +: 16]);
    m_check();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) drive_edge(1'b0, 128'h0, 1'b0);
    rst = 1'b0;
    mq.delete();
    m_rd_data = 16'h0;
  endtask

  initial begin
    logic [127:0] w1;
    logic [127:0] w2;
    logic [127:0] w3;
    logic [127:0] d;
    int af_at;
    int ae_at;

    w1 = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
    w2 = 128'hF00F_E00E_D00D_C00C_B00B_A00A_9009_8008;
    w3 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    //          we    wd    re    rd        emp   wl      rl      ae
    vt[0]  = '{1'b1, w1,   1'b0, 16'h0000, 1'b0, 12'd1,  15'd8,  1'b0};
    vt[1]  = '{1'b0, 128'h0, 1'b1, 16'h0000, 1'b0, 12'd1, 15'd7,  1'b0};
    vt[2]  = '{1'b0, 128'h0, 1'b1, 16'h0001, 1'b0, 12'd1, 15'd6,  1'b0};
    vt[3]  = '{1'b0, 128'h0, 1'b1, 16'h0002, 1'b0, 12'd1, 15'd5,  1'b0};
    vt[4]  = '{1'b0, 128'h0, 1'b1, 16'h0003, 1'b0, 12'd1, 15'd4,  1'b1};
    vt[5]  = '{1'b0, 128'h0, 1'b1, 16'h0004, 1'b0, 12'd1, 15'd3,  1'b1};
    vt[6]  = '{1'b0, 128'h0, 1'b1, 16'h0005, 1'b0, 12'd1, 15'd2,  1'b1};
    vt[7]  = '{1'b0, 128'h0, 1'b1, 16'h0006, 1'b0, 12'd1, 15'd1,  1'b1};
    vt[8]  = '{1'b0, 128'h0, 1'b1, 16'h0007, 1'b1, 12'd0, 15'd0,  1'b1};
    vt[9]  = '{1'b0, 128'h0, 1'b1, 16'h0007, 1'b1, 12'd0, 15'd0,  1'b1};
    vt[10] = '{1'b1, w2,   1'b1, 16'h0007, 1'b0, 12'd1,  15'd8,  1'b0};
    vt[11] = '{1'b0, 128'h0, 1'b1, 16'h8008, 1'b0, 12'd1, 15'd7,  1'b0};
    vt[12] = '{1'b1, w3,   1'b1, 16'h9009, 1'b0, 12'd2,  15'd14, 1'b0};

    u_if.wr_en   = 1'b0;
    u_if.rd_en   = 1'b0;
    u_if.wr_data = 128'h0;

    // Reset values after 20 cycles of rst.
    do_reset(20);
    chk("rst_rd_empty",     32'(u_if.rd_empty),       32'd1);
    chk("rst_almost_empty", 32'(u_if.almost_empty),   32'd1);
    chk("rst_wr_full",      32'(u_if.wr_full),        32'd0);
    chk("rst_almost_full",  32'(u_if.almost_full),    32'd0);
    chk("rst_wr_level",     32'(u_if.wr_water_level), 32'd0);
    chk("rst_rd_level",     32'(u_if.rd_water_level), 32'd0);
    chk("rst_rd_data",      32'(u_if.rd_data),        32'd0);

    // Table: single word lane order, empty-read hold, simultaneous ops.
    for (int i = 0; i < 13; i++) begin
      drive_edge(vt[i].we, vt[i].wd, vt[i].re);
      chk($sformatf("vec%0d_rd_data", i),  32'(u_if.rd_data),        32'(vt[i].rd));
      chk($sformatf("vec%0d_rd_empty", i), 32'(u_if.rd_empty),       32'(vt[i].emp));
      chk($sformatf("vec%0d_wr_level", i), 32'(u_if.wr_water_level), 32'(vt[i].wl));
      chk($sformatf("vec%0d_rd_level", i), 32'(u_if.rd_water_level), 32'(vt[i].rl));
      chk($sformatf("vec%0d_almost_empty", i), 32'(u_if.almost_empty), 32'(vt[i].ae));
      chk($sformatf("vec%0d_wr_full", i),  32'(u_if.wr_full),        32'd0);
    end

    // Fill with 2049 writes of a down-counter; the last one must be dropped.
    do_reset(2);
    af_at = -1;
    for (int i = 0; i < 2049; i++) begin
      d = {128{1'b1}} - 128'(i);
      m_cycle(1'b1, d, 1'b0);
      if (af_at < 0 && u_if.almost_full === 1'b1) af_at = i + 1;
    end
    chk("fill_almost_full_at", 32'(af_at), 32'd508);
    chk("fill_wr_full",  32'(u_if.wr_full),        32'd1);
    chk("fill_wr_level", 32'(u_if.wr_water_level), 32'd2048);
    chk("fill_rd_level", 32'(u_if.rd_water_level), 32'd16384);

    // Drain with 16385 reads; the extra read must leave rd_data alone.
    ae_at = -1;
    for (int i = 0; i < 16385; i++) begin
      m_cycle(1'b0, 128'h0, 1'b1);
      if (ae_at < 0 && u_if.almost_empty === 1'b1) ae_at = i + 1;
    end
    chk("drain_almost_empty_at", 32'(ae_at), 32'd16380);
    chk("drain_rd_empty",  32'(u_if.rd_empty), 32'd1);
    chk("drain_last_data", 32'(u_if.rd_data),  32'h0000_FFFF);

    // Concurrent: 2 words queued, then write and read every cycle.
    do_reset(2);
    m_cycle(1'b1, 128'hA1A1_A2A2_A3A3_A4A4_A5A5_A6A6_A7A7_A8A8, 1'b0);
    m_cycle(1'b1, 128'hB1B1_B2B2_B3B3_B4B4_B5B5_B6B6_B7B7_B8B8, 1'b0);
    for (int i = 0; i < 100; i++) begin
      d = {32'(i) * 32'h0101_0101, 32'hC0DE_0000 + 32'(i),
           32'h5A5A_0000 + 32'(i), 32'(i) ^ 32'hFFFF_0000};
      m_cycle(1'b1, d, 1'b1);
    end
    chk("conc_rd_level", 32'(u_if.rd_water_level), 32'd716);

    // Reset while half full, then confirm fresh data replaces stale contents.
    do_reset(2);
    for (int i = 0; i < 1024; i++) begin
      m_cycle(1'b1, {4{32'hDEAD_0000 + 32'(i)}}, 1'b0);
    end
    do_reset(1);
    chk("mid_rst_rd_empty", 32'(u_if.rd_empty),       32'd1);
    chk("mid_rst_wr_level", 32'(u_if.wr_water_level), 32'd0);
    chk("mid_rst_rd_level", 32'(u_if.rd_water_level), 32'd0);
    chk("mid_rst_rd_data",  32'(u_if.rd_data),        32'd0);
    m_cycle(1'b1, 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978, 1'b0);
    for (int i = 0; i < 8; i++) m_cycle(1'b0, 128'h0, 1'b1);
    chk("post_rst_last_lane", 32'(u_if.rd_data), 32'h0000_1234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fifo_128to16_sync
